// File: rtl/host_tx_pkg.sv
// Shared types and default widths for the multi-queue host transmit read controller.
package host_tx_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StArb      = 3'd1,
        StWaitReq  = 3'd2,
        StWaitAck  = 3'd3,
        StWaitData = 3'd4,
        StRelease  = 3'd5
    } read_state_e;

    localparam int unsigned DefNumQ    = 4;
    localparam int unsigned DefQDepth  = 8;
    localparam int unsigned DefBufidW  = 9;
    localparam int unsigned DefInportW = 4;
    localparam int unsigned DefLineW   = 7;

endpackage

// File: rtl/host_desc_fifo.sv
// Single descriptor queue: synchronous FIFO that accepts a push while full
// only when it is popped in the same cycle.
module host_desc_fifo #(
    parameter int unsigned DESC_W  = 13,
    parameter int unsigned Q_DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DESC_W-1:0] iv_din,
    output logic              o_full,
    output logic              o_empty,
    output logic [DESC_W-1:0] ov_dout
);

    localparam int unsigned PTR_W = $clog2(Q_DEPTH);

    logic [DESC_W-1:0] mem_q [Q_DEPTH];
    logic [PTR_W:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic              do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (wptr_q == rptr_q);
    assign o_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);
    assign ov_dout = mem_q[rptr_q[PTR_W-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= iv_din;
    end

endmodule

// File: rtl/host_tx_mq_read_ctrl.sv
// Multi-queue host transmit read controller: arbitrates descriptor queues and issues
// per-line reads, then releases the buffer. Define HOST_TX_SP_EN for strict priority.
module host_tx_mq_read_ctrl
    import host_tx_pkg::*;
#(
    parameter int unsigned NUM_Q    = DefNumQ,
    parameter int unsigned Q_DEPTH  = DefQDepth,
    parameter int unsigned BUFID_W  = DefBufidW,
    parameter int unsigned INPORT_W = DefInportW,
    parameter int unsigned LINE_W   = DefLineW
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_Q*(INPORT_W+BUFID_W)-1:0] iv_pkt_descriptor,
    input  logic [NUM_Q-1:0]            iv_pkt_descriptor_wr,
    output logic [NUM_Q-1:0]            ov_pkt_descriptor_ready,
    output logic [NUM_Q-1:0]            o_desc_overflow_pulse,
    input  logic                        i_pkt_rd_req,
    output logic [BUFID_W+LINE_W-1:0]   ov_pkt_raddr,
    output logic                        o_pkt_rd,
    input  logic                        i_pkt_raddr_ack,
    input  logic                        i_pkt_last_cycle_rx,
    output logic [INPORT_W-1:0]         ov_pkt_inport,
    output logic [$clog2(NUM_Q)-1:0]    ov_pkt_qid,
    output logic [BUFID_W-1:0]          ov_pkt_bufid,
    output logic                        o_pkt_bufid_wr,
    input  logic                        i_pkt_bufid_ack,
    output logic                        o_len_err_pulse,
    output logic [2:0]                  ov_read_state
);

    localparam int unsigned DESC_W = INPORT_W + BUFID_W;
    localparam int unsigned QID_W  = $clog2(NUM_Q);
    localparam int unsigned ADDR_W = BUFID_W + LINE_W;

    logic [NUM_Q-1:0]  q_full, q_empty, q_pop;
    logic [DESC_W-1:0] q_dout [NUM_Q];

    for (genvar g = 0; g < NUM_Q; g++) begin : g_queue
        host_desc_fifo #(
            .DESC_W  (DESC_W),
            .Q_DEPTH (Q_DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_push  (iv_pkt_descriptor_wr[g]),
            .i_pop   (q_pop[g]),
            .iv_din  (iv_pkt_descriptor[g*DESC_W +: DESC_W]),
            .o_full  (q_full[g]),
            .o_empty (q_empty[g]),
            .ov_dout (q_dout[g])
        );
    end

    read_state_e         state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [BUFID_W-1:0]  bufid_q, bufid_d;
    logic [INPORT_W-1:0] inport_q, inport_d;
    logic [QID_W-1:0]    qid_q, qid_d;
    logic                last_pend_q, last_pend_d;
    logic                len_err_q, len_err_d;
    logic [NUM_Q-1:0]    ovf_q, ovf_d;
    logic                grant_found;
    logic [QID_W-1:0]    grant_qid, cand_qid;
    logic [DESC_W-1:0]   grant_desc;
    logic                last_seen;

`ifdef HOST_TX_SP_EN
    always_comb begin
        grant_found = 1'b0;
        grant_qid   = '0;
        cand_qid    = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            cand_qid = QID_W'(i);
            if (!grant_found && !q_empty[cand_qid]) begin
                grant_found = 1'b1;
                grant_qid   = cand_qid;
            end
        end
    end
`else
    logic [QID_W-1:0] rr_ptr_q, rr_ptr_d;

    // Search starts just after the last winner so every queue gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_qid   = '0;
        cand_qid    = '0;
        for (int i = 1; i <= NUM_Q; i++) begin
            cand_qid = QID_W'((int'(rr_ptr_q) + i) % int'(NUM_Q));
            if (!grant_found && !q_empty[cand_qid]) begin
                grant_found = 1'b1;
                grant_qid   = cand_qid;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == StArb && grant_found) rr_ptr_d = grant_qid;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) rr_ptr_q <= QID_W'(NUM_Q - 1);
        else       rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign grant_desc = q_dout[grant_qid];
    assign last_seen  = i_pkt_last_cycle_rx || last_pend_q;
    assign ovf_d      = iv_pkt_descriptor_wr & q_full & ~q_pop;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        raddr_d     = raddr_q;
        bufid_d     = bufid_q;
        inport_d    = inport_q;
        qid_d       = qid_q;
        last_pend_d = last_pend_q;
        len_err_d   = 1'b0;
        q_pop       = '0;
        unique case (state_q)
            StIdle: if (q_empty != '1) state_d = StArb;
            StArb: begin
                if (grant_found) begin
                    q_pop[grant_qid] = 1'b1;
                    bufid_d     = grant_desc[BUFID_W-1:0];
                    inport_d    = grant_desc[DESC_W-1:BUFID_W];
                    qid_d       = grant_qid;
                    line_d      = '0;
                    last_pend_d = 1'b0;
                    state_d     = StWaitReq;
                end else begin
                    state_d = StIdle;
                end
            end
            StWaitReq: begin
                if (i_pkt_last_cycle_rx) last_pend_d = 1'b1;
                if (i_pkt_rd_req) begin
                    raddr_d = {bufid_q, line_q};
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (i_pkt_last_cycle_rx) last_pend_d = 1'b1;
                if (i_pkt_raddr_ack) begin
                    line_d  = line_q + 1'b1;
                    state_d = StWaitData;
                end
            end
            StWaitData: begin
                if (last_seen) begin
                    state_d = StRelease;
                end else if (line_q == '0) begin
                    // Counter wrapped: every line index used and still no last.
                    len_err_d = 1'b1;
                    state_d   = StRelease;
                end else if (i_pkt_rd_req) begin
                    raddr_d = {bufid_q, line_q};
                    state_d = StWaitAck;
                end
            end
            StRelease: if (i_pkt_bufid_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            line_q      <= '0;
            raddr_q     <= '0;
            bufid_q     <= '0;
            inport_q    <= '0;
            qid_q       <= '0;
            last_pend_q <= 1'b0;
            len_err_q   <= 1'b0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            raddr_q     <= raddr_d;
            bufid_q     <= bufid_d;
            inport_q    <= inport_d;
            qid_q       <= qid_d;
            last_pend_q <= last_pend_d;
            len_err_q   <= len_err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ov_pkt_descriptor_ready = ~q_full;
    assign o_desc_overflow_pulse   = ovf_q;
    assign ov_pkt_raddr            = raddr_q;
    assign o_pkt_rd                = (state_q == StWaitAck);
    assign ov_pkt_inport           = inport_q;
    assign ov_pkt_qid              = qid_q;
    assign ov_pkt_bufid            = bufid_q;
    assign o_pkt_bufid_wr          = (state_q == StRelease);
    assign o_len_err_pulse         = len_err_q;
    assign ov_read_state           = state_q;

endmodule
